// File: rtl/or1k_wb_ext_arbiter.sv
// or1k_wb_ext_arbiter
// Shares one external Wishbone slave among NODES tile masters. Masters are
// granted round-robin. An owner keeps the bus until it drops m_cyc_i, so bursts
// and stb-low gaps are never split. While a master owns the bus, its request
// passes straight through to the slave and the slave's responses go back to
// that master only. A wait counter reports a stalled access as a one-cycle
// error to the owner, without taking the bus away from it.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   m_*_i             per-master Wishbone request (adr, dat, sel, cyc, stb, we,
//                     cab, cti, bte)
//   m_ack_o/err_o/rty_o, m_dat_o
//                     per-master responses and read data
//   s_*_o             shared slave request
//   s_ack_i/err_i/rty_i, s_dat_i
//                     slave responses and read data
//   grant_o           one-hot current owner; zero when idle
module or1k_wb_ext_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned NODES   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NODES-1:0][AW-1:0]  m_adr_i,
  input  logic [NODES-1:0][DW-1:0]  m_dat_i,
  input  logic [NODES-1:0]          m_cyc_i,
  input  logic [NODES-1:0]          m_stb_i,
  input  logic [NODES-1:0]          m_we_i,
  input  logic [NODES-1:0]          m_cab_i,
  input  logic [NODES-1:0][3:0]     m_sel_i,
  input  logic [NODES-1:0][2:0]     m_cti_i,
  input  logic [NODES-1:0][1:0]     m_bte_i,
  output logic [NODES-1:0]          m_ack_o,
  output logic [NODES-1:0]          m_err_o,
  output logic [NODES-1:0]          m_rty_o,
  output logic [NODES-1:0][DW-1:0]  m_dat_o,
  output logic [AW-1:0]             s_adr_o,
  output logic [DW-1:0]             s_dat_o,
  output logic [3:0]                s_sel_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic                      s_cab_o,
  output logic [2:0]                s_cti_o,
  output logic [1:0]                s_bte_o,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  input  logic                      s_rty_i,
  input  logic [DW-1:0]             s_dat_i,
  output logic [NODES-1:0]          grant_o
);

  localparam int unsigned IW = (NODES > 1) ? $clog2(NODES) : 1;
  localparam int unsigned CW = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] pick;
  logic          pick_vld;
  logic          own_cyc;
  logic          own_stb;
  logic          resp;
  logic          timeout;

  // Round-robin search: first requester after the previous owner, wrapping.
  always_comb begin : p_pick
    int unsigned   idx;
    logic [IW-1:0] cand;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    cand     = '0;
    for (int unsigned k = 1; k <= NODES; k++) begin
      idx  = (32'(last_q) + k) % NODES;
      cand = IW'(idx);
      if (!pick_vld && m_cyc_i[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  // State register; reset leaves the next search starting at index 0.
  always_ff @(posedge clk or negedge rst) begin : p_state
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NODES - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, owner pass-through, response routing and wait counter.
  always_comb begin : p_fsm
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = '0;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    resp    = 1'b0;
    timeout = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_cab_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    grant_o = '0;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = BUSY;
          owner_d = pick;
        end
      end
      BUSY: begin
        own_cyc = m_cyc_i[owner_q];
        own_stb = m_stb_i[owner_q];
        resp    = s_ack_i | s_err_i | s_rty_i;
        // A real slave response in the same cycle wins over the timeout.
        timeout = own_stb && !resp && (cnt_q == CW'(TIMEOUT));

        grant_o[owner_q] = 1'b1;
        s_adr_o = m_adr_i[owner_q];
        s_dat_o = m_dat_i[owner_q];
        s_sel_o = m_sel_i[owner_q];
        s_cyc_o = own_cyc;
        s_stb_o = own_stb & ~timeout;
        s_we_o  = m_we_i[owner_q];
        s_cab_o = m_cab_i[owner_q];
        s_cti_o = m_cti_i[owner_q];
        s_bte_o = m_bte_i[owner_q];

        m_ack_o[owner_q] = s_ack_i;
        m_err_o[owner_q] = s_err_i | timeout;
        m_rty_o[owner_q] = s_rty_i;

        // Count only stalled strobes; any response, gap or timeout clears.
        if (s_stb_o && !resp) begin
          cnt_d = cnt_q + CW'(1);
        end

        if (!own_cyc) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data is shared; each master sees it only alongside its own ack.
  always_comb begin : p_rdata
    for (int unsigned i = 0; i < NODES; i++) begin
      m_dat_o[i] = m_ack_o[i] ? s_dat_i : '0;
    end
  end

endmodule

// File: tb/tb_or1k_wb_ext_arbiter.sv
module tb_or1k_wb_ext_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned N  = 8;

  logic clk = 1'b0;
  logic rst;

  logic [N-1:0][AW-1:0] m_adr_i;
  logic [N-1:0][DW-1:0] m_dat_i;
  logic [N-1:0]         m_cyc_i, m_stb_i, m_we_i, m_cab_i;
  logic [N-1:0][3:0]    m_sel_i;
  logic [N-1:0][2:0]    m_cti_i;
  logic [N-1:0][1:0]    m_bte_i;
  logic [N-1:0]         m_ack_o, m_err_o, m_rty_o;
  logic [N-1:0][DW-1:0] m_dat_o;
  logic [AW-1:0]        s_adr_o;
  logic [DW-1:0]        s_dat_o;
  logic [3:0]           s_sel_o;
  logic                 s_cyc_o, s_stb_o, s_we_o, s_cab_o;
  logic [2:0]           s_cti_o;
  logic [1:0]           s_bte_o;
  logic                 s_ack_i, s_err_i, s_rty_i;
  logic [DW-1:0]        s_dat_i;
  logic [N-1:0]         grant_o;

  or1k_wb_ext_arbiter #(.AW(AW), .DW(DW), .NODES(N), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_we_i(m_we_i), .m_cab_i(m_cab_i), .m_sel_i(m_sel_i), .m_cti_i(m_cti_i),
    .m_bte_i(m_bte_i), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .m_dat_o(m_dat_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_cab_o(s_cab_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .s_rty_i(s_rty_i), .s_dat_i(s_dat_i), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cyc;
    logic [7:0] stb;
    logic       ack;
    logic       err;
    logic       rty;
    logic [7:0] e_grant;
    logic       e_scyc;
    logic       e_sstb;
    logic [7:0] e_ack;
    logic [7:0] e_err;
    logic [7:0] e_rty;
    int         e_src;
  } vec_t;

  vec_t tv[16];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [7:0]    WE_PAT  = 8'hAA;
  localparam logic [7:0]    CAB_PAT = 8'h0F;
  localparam logic [DW-1:0] SDAT    = 32'hCAFE_0123;

  function automatic logic [AW-1:0] adr_of(input int k);
    return 32'h1000_0000 + 32'(k) * 32'h100;
  endfunction

  function automatic logic [DW-1:0] dat_of(input int k);
    return 32'hD000_0000 + 32'(k);
  endfunction

  function automatic logic [3:0] sel_of(input int k);
    return 4'hF ^ 4'(k);
  endfunction

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_cyc_i = '0;
    m_stb_i = '0;
    m_cti_i = '0;
    m_bte_i = '0;
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
    s_rty_i = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #4;
    rst = 1'b1;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_g;
    int         acks5;

    rst = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      m_adr_i[i] = adr_of(i);
      m_dat_i[i] = dat_of(i);
      m_sel_i[i] = sel_of(i);
    end
    m_we_i  = WE_PAT;
    m_cab_i = CAB_PAT;
    s_dat_i = SDAT;
    idle_inputs();

    //                cyc    stb    a    e    r    grant  scyc stb  ack    err    rty   src
    tv[0]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, -1};
    tv[1]  = '{8'h04, 8'h04, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, -1};
    tv[2]  = '{8'h04, 8'h04, 1'b0, 1'b0, 1'b0, 8'h04, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00,  2};
    tv[3]  = '{8'h04, 8'h04, 1'b0, 1'b0, 1'b0, 8'h04, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00,  2};
    tv[4]  = '{8'h04, 8'h04, 1'b0, 1'b0, 1'b0, 8'h04, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00,  2};
    tv[5]  = '{8'h04, 8'h04, 1'b1, 1'b0, 1'b0, 8'h04, 1'b1, 1'b1, 8'h04, 8'h00, 8'h00,  2};
    tv[6]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h04, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00,  2};
    tv[7]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, -1};
    tv[8]  = '{8'h09, 8'h09, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, -1};
    tv[9]  = '{8'h09, 8'h09, 1'b0, 1'b0, 1'b1, 8'h08, 1'b1, 1'b1, 8'h00, 8'h00, 8'h08,  3};
    tv[10] = '{8'h09, 8'h09, 1'b0, 1'b1, 1'b0, 8'h08, 1'b1, 1'b1, 8'h00, 8'h08, 8'h00,  3};
    tv[11] = '{8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00,  3};
    tv[12] = '{8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, -1};
    tv[13] = '{8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1, 8'h01, 8'h00, 8'h00,  0};
    tv[14] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00,  0};
    tv[15] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, -1};

    // Outputs held quiet while reset is asserted.
    #3;
    chk("reset grant", grant_o, 8'h00);
    chk("reset s_cyc", s_cyc_o, 1'b0);
    chk("reset s_adr", s_adr_o, 32'h0);

    // Table: single request, response routing, release then re-request.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      int src;
      next();
      m_cyc_i = tv[i].cyc;
      m_stb_i = tv[i].stb;
      s_ack_i = tv[i].ack;
      s_err_i = tv[i].err;
      s_rty_i = tv[i].rty;
      #1;
      src = tv[i].e_src;
      chk($sformatf("vec%0d grant", i), grant_o, tv[i].e_grant);
      chk($sformatf("vec%0d s_cyc", i), s_cyc_o, tv[i].e_scyc);
      chk($sformatf("vec%0d s_stb", i), s_stb_o, tv[i].e_sstb);
      chk($sformatf("vec%0d m_ack", i), m_ack_o, tv[i].e_ack);
      chk($sformatf("vec%0d m_err", i), m_err_o, tv[i].e_err);
      chk($sformatf("vec%0d m_rty", i), m_rty_o, tv[i].e_rty);
      chk($sformatf("vec%0d s_adr", i), s_adr_o, (src >= 0) ? adr_of(src) : 32'h0);
      chk($sformatf("vec%0d s_dat", i), s_dat_o, (src >= 0) ? dat_of(src) : 32'h0);
      chk($sformatf("vec%0d s_sel", i), s_sel_o, (src >= 0) ? sel_of(src) : 4'h0);
      chk($sformatf("vec%0d s_we", i), s_we_o, (src >= 0) ? WE_PAT[src] : 1'b0);
      chk($sformatf("vec%0d s_cab", i), s_cab_o, (src >= 0) ? CAB_PAT[src] : 1'b0);
      for (int m = 0; m < int'(N); m++) begin
        chk($sformatf("vec%0d m_dat[%0d]", i, m), m_dat_o[m],
            tv[i].e_ack[m] ? SDAT : 32'h0);
      end
    end

    // Fairness: everyone requests; owner leaves after one ack.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      exp_g = 8'(1 << (k % 8));
      next();
      m_cyc_i = 8'hFF;
      m_stb_i = 8'hFF;
      s_ack_i = 1'b0;
      #1;
      chk($sformatf("rr%0d idle grant", k), grant_o, 8'h00);
      chk($sformatf("rr%0d idle s_cyc", k), s_cyc_o, 1'b0);
      next();
      s_ack_i = 1'b1;
      #1;
      chk($sformatf("rr%0d grant", k), grant_o, exp_g);
      chk($sformatf("rr%0d m_ack", k), m_ack_o, exp_g);
      chk($sformatf("rr%0d s_adr", k), s_adr_o, adr_of(k % 8));
      next();
      s_ack_i = 1'b0;
      m_cyc_i = 8'hFF & ~exp_g;
      m_stb_i = 8'hFF & ~exp_g;
      #1;
      chk($sformatf("rr%0d release grant", k), grant_o, exp_g);
      chk($sformatf("rr%0d release s_cyc", k), s_cyc_o, 1'b0);
    end

    // Burst lock: master 5 bursts with a stb gap while master 6 waits.
    do_reset();
    acks5 = 0;
    next();
    m_cyc_i = 8'h60;
    m_stb_i = 8'h60;
    m_cti_i[5] = 3'b010;
    m_bte_i[5] = 2'b01;
    #1;
    chk("burst idle grant", grant_o, 8'h00);
    for (int b = 0; b < 5; b++) begin
      next();
      if (b == 2) begin
        m_stb_i = 8'h40;
        s_ack_i = 1'b0;
      end else begin
        m_stb_i = 8'h60;
        s_ack_i = 1'b1;
      end
      if (b == 4) m_cti_i[5] = 3'b111;
      #1;
      chk($sformatf("burst%0d grant", b), grant_o, 8'h20);
      chk($sformatf("burst%0d m_ack", b), m_ack_o, (b == 2) ? 8'h00 : 8'h20);
      chk($sformatf("burst%0d s_stb", b), s_stb_o, (b == 2) ? 1'b0 : 1'b1);
      chk($sformatf("burst%0d s_cti", b), s_cti_o, (b == 4) ? 3'b111 : 3'b010);
      chk($sformatf("burst%0d s_bte", b), s_bte_o, 2'b01);
      acks5 += int'(m_ack_o[5]);
    end
    next();
    s_ack_i = 1'b0;
    m_cyc_i = 8'h40;
    m_stb_i = 8'h40;
    #1;
    chk("burst release grant", grant_o, 8'h20);
    chk("burst release s_cyc", s_cyc_o, 1'b0);
    chk("burst ack count", acks5, 4);
    next();
    #1;
    chk("burst gap grant", grant_o, 8'h00);
    chk("burst gap s_cyc", s_cyc_o, 1'b0);
    next();
    #1;
    chk("burst m6 grant", grant_o, 8'h40);
    chk("burst m6 s_adr", s_adr_o, adr_of(6));
    chk("burst m6 s_cti", s_cti_o, 3'b000);
    next();
    idle_inputs();

    // Timeout: silent slave, then an ack exactly at the timeout count.
    do_reset();
    next();
    m_cyc_i = 8'h02;
    m_stb_i = 8'h02;
    #1;
    chk("to idle grant", grant_o, 8'h00);
    for (int c = 0; c < 4; c++) begin
      next();
      chk($sformatf("to wait%0d s_stb", c), s_stb_o, 1'b1);
      chk($sformatf("to wait%0d m_err", c), m_err_o, 8'h00);
    end
    next();
    chk("to fire m_err", m_err_o, 8'h02);
    chk("to fire s_stb", s_stb_o, 1'b0);
    chk("to fire grant", grant_o, 8'h02);
    for (int c = 0; c < 4; c++) begin
      next();
      chk($sformatf("to rewait%0d s_stb", c), s_stb_o, 1'b1);
      chk($sformatf("to rewait%0d m_err", c), m_err_o, 8'h00);
      chk($sformatf("to rewait%0d grant", c), grant_o, 8'h02);
    end
    next();
    s_ack_i = 1'b1;
    #1;
    chk("to ack wins m_ack", m_ack_o, 8'h02);
    chk("to ack wins m_err", m_err_o, 8'h00);
    chk("to ack wins s_stb", s_stb_o, 1'b1);
    next();
    s_ack_i = 1'b0;
    #1;
    chk("to after ack m_err", m_err_o, 8'h00);
    next();
    idle_inputs();
    next();

    // Reset mid-transfer of master 1, then masters 0 and 1 request.
    next();
    m_cyc_i = 8'h02;
    m_stb_i = 8'h02;
    #1;
    chk("rst idle grant", grant_o, 8'h00);
    next();
    s_ack_i = 1'b1;
    #1;
    chk("rst busy s_cyc", s_cyc_o, 1'b1);
    chk("rst busy m_ack", m_ack_o, 8'h02);
    rst = 1'b0;
    #1;
    chk("rst async s_cyc", s_cyc_o, 1'b0);
    chk("rst async grant", grant_o, 8'h00);
    chk("rst async m_ack", m_ack_o, 8'h00);
    #1;
    s_ack_i = 1'b0;
    m_cyc_i = 8'h03;
    m_stb_i = 8'h03;
    #2;
    rst = 1'b1;
    next();
    chk("rst regrant grant", grant_o, 8'h01);
    chk("rst regrant s_adr", s_adr_o, adr_of(0));
    next();
    idle_inputs();
    next();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/or1k_wb_ext_arbiter.md
OR1K_WB_EXT_ARBITER -- requirements
Module: or1k_wb_ext_arbiter

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter NODES, default 8, number of tile Wishbone masters sharing one external slave.
REQ-004 Parameter TIMEOUT, default 255, maximum wait in cycles for ack/err/rty; range 1..65535.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 m_adr_i, m_dat_i  input  [NODES-1:0][AW-1:0] / [NODES-1:0][DW-1:0]  per-master address and write data.
REQ-008 m_cyc_i, m_stb_i, m_we_i, m_cab_i  input  [NODES-1:0]  per-master bus controls.
REQ-009 m_sel_i, m_cti_i, m_bte_i  input  [NODES-1:0][3:0] / [2:0] / [1:0]  per-master select, cycle type and burst type.
REQ-010 m_ack_o, m_err_o, m_rty_o  output  [NODES-1:0]  per-master responses.
REQ-011 m_dat_o  output  [NODES-1:0][DW-1:0]  per-master read data.
REQ-012 s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o, s_cab_o, s_cti_o, s_bte_o  output  AW/DW/4/1/1/1/1/3/2  shared external slave request.
REQ-013 s_ack_i, s_err_i, s_rty_i  input  1  slave responses; s_dat_i  input  DW  slave read data.
REQ-014 grant_o  output  [NODES-1:0]  one-hot current owner; all zero when idle.

Function
REQ-015 FSM states: IDLE, BUSY. IDLE means no owner. BUSY means exactly one owner.
REQ-016 In IDLE, when any m_cyc_i bit is high, the owner is chosen round-robin. Search starts at index last+1 mod NODES, where last is the previous owner (reset value NODES-1). Selection is registered, and the FSM moves to BUSY on the next edge.
REQ-017 Arbitration latency is 1 cycle: a request first seen at edge n drives s_cyc_o from cycle n+1.
REQ-018 In BUSY, all s_* request outputs are combinational pass-through of the owner's m_* inputs.
REQ-019 In BUSY, s_ack_i, s_err_i and s_rty_i route only to the owner. All other m_ack_o, m_err_o and m_rty_o outputs are 0.
REQ-020 m_dat_o of every master equals s_dat_i; this is qualified by that master's ack.
REQ-021 In IDLE, every s_* request output is 0 and every m_* response output is 0.
REQ-022 BUSY returns to IDLE on the edge where the owner's m_cyc_i is sampled low; last is updated to the owner.
REQ-023 The bus is never preempted while the owner holds m_cyc_i, including across bursts (cti 3'b001/3'b010) and across stb-low gaps.
REQ-024 Release and a new request in the same cycle: the FSM spends exactly one IDLE cycle before the new grant, and s_cyc_o stays low in that cycle.
REQ-025 A 16-bit wait counter clears whenever the owner's stb is low or any slave response is seen; otherwise it increments while s_stb_o is high.
REQ-026 When the counter equals TIMEOUT, m_err_o of the owner is asserted for exactly one cycle and s_stb_o is forced low that cycle. The counter then clears and ownership is retained.
REQ-027 A slave response arriving in the same cycle as a timeout has priority. It is passed through, and no error is generated.
REQ-028 grant_o equals the registered owner one-hot in BUSY.

Reset
REQ-029 Asserting rst low forces IDLE immediately, regardless of clk: grant_o=0, every s_* output =0, every m_* response =0, wait counter=0, last=NODES-1.
REQ-030 Reset asserted mid-transfer drops s_cyc_o asynchronously; no response is delivered for the aborted access.
REQ-031 On release of rst, the first grant follows REQ-016 starting at index 0.

Verification
REQ-032 Single request: after reset, m_cyc_i[2]=1 with stb; slave acks after 3 cycles -> grant_o=8'h04 one cycle later, s_adr_o=m_adr_i[2], m_ack_o[2] pulses once, other ack bits 0.
REQ-033 Fairness: all 8 masters request continuously, and each drops cyc after one ack -> grant sequence 0,1,...,7,0 with one IDLE cycle between grants.
REQ-034 Burst lock: master 5 issues a 4-beat cti=3'b010 burst while master 6 requests -> master 6 is granted only after master 5 drops cyc; 4 acks go to master 5 only.
REQ-035 Timeout: TIMEOUT=4 and the slave never responds -> m_err_o[owner] pulses once 4 cycles after stb is asserted, s_stb_o is low in that cycle, and ownership is kept; an ack in that same cycle suppresses the err.
REQ-036 Reset mid-operation: rst is pulled low during an active transfer of master 1 -> s_cyc_o=0 and grant_o=0 without a clk edge. After release, with masters 0 and 1 requesting, master 0 is granted first.
